// File: rtl/upsampler_ce_scheduler.sv
// rtl/upsampler_ce_scheduler.sv - cascaded clock-enable scheduler for the x2 / x2 / xR interpolation chain
// with a one-entry input sample buffer handed to the half-band stage on hb_ce.
module upsampler_ce_scheduler #(
  parameter int DW           = 16,
  parameter int RATE_W       = 11,
  parameter int DEFAULT_RATE = 1625,
  parameter int HB_FACTOR    = 2,
  parameter int COMP_FACTOR  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_in,
  input  logic              rate_load,
  input  logic [DW-1:0]     s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DW-1:0]     sample_out,
  output logic              hb_ce,
  output logic              comp_ce,
  output logic              cic_ce,
  output logic [RATE_W-1:0] rate_active,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int CC_W = (COMP_FACTOR > 1) ? $clog2(COMP_FACTOR) : 1;
  localparam int HC_W = (HB_FACTOR > 1) ? $clog2(HB_FACTOR) : 1;
  localparam logic [CC_W-1:0]   CC_LAST    = CC_W'(COMP_FACTOR - 1);
  localparam logic [HC_W-1:0]   HC_LAST    = HC_W'(HB_FACTOR - 1);
  localparam logic [RATE_W-1:0] MIN_RATE   = RATE_W'(2);
  localparam logic [RATE_W-1:0] RESET_RATE = RATE_W'(DEFAULT_RATE);

  logic [RATE_W-1:0] rc;
  logic [CC_W-1:0]   cc;
  logic [HC_W-1:0]   hc;
  logic [RATE_W-1:0] rate_pending;
  logic [RATE_W-1:0] pending_next;
  logic              full;
  logic [DW-1:0]     buf_data;
  logic              rc_wrap;
  logic              cc_wrap;
  logic              hb_fire;
  logic              xfer;

  // Wrap conditions decided a cycle ahead so the strobes come out registered.
  always_comb begin
    rc_wrap      = enable && (rc == (rate_active - RATE_W'(1)));
    cc_wrap      = rc_wrap && (cc == CC_LAST);
    hb_fire      = cc_wrap && (hc == HC_LAST);
    xfer         = s_tvalid && !full;
    pending_next = rate_pending;
    if (rate_load) begin
      pending_next = (rate_in < MIN_RATE) ? MIN_RATE : rate_in;
    end
  end

  assign s_tready = !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc      <= '0;
      cc      <= '0;
      hc      <= '0;
      cic_ce  <= 1'b0;
      comp_ce <= 1'b0;
      hb_ce   <= 1'b0;
    end else if (!enable) begin
      rc      <= '0;
      cc      <= '0;
      hc      <= '0;
      cic_ce  <= 1'b0;
      comp_ce <= 1'b0;
      hb_ce   <= 1'b0;
    end else begin
      rc      <= rc_wrap ? '0 : rc + RATE_W'(1);
      cic_ce  <= rc_wrap;
      comp_ce <= cc_wrap;
      hb_ce   <= hb_fire;
      if (rc_wrap) begin
        cc <= (cc == CC_LAST) ? '0 : cc + CC_W'(1);
      end
      if (cc_wrap) begin
        hc <= (hc == HC_LAST) ? '0 : hc + HC_W'(1);
      end
    end
  end

  // A new rate only takes effect on a frame boundary, or at once while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_pending <= RESET_RATE;
      rate_active  <= RESET_RATE;
    end else begin
      rate_pending <= pending_next;
      if (!enable || hb_fire) begin
        rate_active <= pending_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full       <= 1'b0;
      buf_data   <= '0;
      sample_out <= '0;
      underrun   <= 1'b0;
    end else begin
      if (hb_fire) begin
        sample_out <= full ? buf_data : '0;
      end
      if (xfer) begin
        full     <= 1'b1;
        buf_data <= s_tdata;
      end else if (hb_fire) begin
        full <= 1'b0;
      end
      if (hb_fire && !full) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_upsampler_ce_scheduler.sv
// tb/tb_upsampler_ce_scheduler.sv - self-checking bench for upsampler_ce_scheduler
// (vector table, directed corner sequences, randomized run against a frame-position model).
module tb_upsampler_ce_scheduler;

  localparam int DW = 16;
  localparam int RW = 11;
  localparam int DEF_RATE = 1625;
  localparam int HBF = 2;
  localparam int CPF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [RW-1:0] rate_in = '0;
  logic          rate_load = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] sample_out;
  logic          hb_ce, comp_ce, cic_ce;
  logic [RW-1:0] rate_active;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  upsampler_ce_scheduler #(
    .DW(DW), .RATE_W(RW), .DEFAULT_RATE(DEF_RATE), .HB_FACTOR(HBF), .COMP_FACTOR(CPF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_in(rate_in), .rate_load(rate_load),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .sample_out(sample_out),
    .hb_ce(hb_ce), .comp_ce(comp_ce), .cic_ce(cic_ce), .rate_active(rate_active),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position inside the frame and the rate in force.
  int            m_n, m_r, m_pend;
  bit            m_full, m_cic, m_comp, m_hb, m_under;
  logic [DW-1:0] m_buf, m_sample;

  typedef struct {
    logic          en, ld;
    logic [RW-1:0] rin;
    logic          tv;
    logic [DW-1:0] td;
    logic          clr;
    logic          e_cic, e_comp, e_hb;
    logic [DW-1:0] e_sample;
    logic          e_tready;
    logic [RW-1:0] e_rate;
    logic          e_under;
  } vec_t;

  vec_t vecs[37];

  function automatic logic [31:0] pack_dut();
    return {cic_ce, comp_ce, hb_ce, sample_out, s_tready, rate_active, underrun};
  endfunction

  function automatic logic [31:0] pack_model();
    return {m_cic, m_comp, m_hb, m_sample, !m_full, RW'(m_r), m_under};
  endfunction

  function automatic void model_reset();
    m_n = 0; m_r = DEF_RATE; m_pend = DEF_RATE;
    m_full = 0; m_cic = 0; m_comp = 0; m_hb = 0; m_under = 0;
    m_buf = '0; m_sample = '0;
  endfunction

  function automatic void model_edge();
    int  pn;
    bit  x;
    pn = rate_load ? ((rate_in < 2) ? 2 : int'(rate_in)) : m_pend;
    x  = s_tvalid && !m_full;
    if (!enable) begin
      m_n = 0; m_cic = 0; m_comp = 0; m_hb = 0; m_r = pn;
    end else begin
      m_n++;
      m_cic  = (m_n % m_r) == 0;
      m_comp = (m_n % (CPF * m_r)) == 0;
      m_hb   = (m_n % (HBF * CPF * m_r)) == 0;
    end
    if (m_hb && !m_full) m_under = 1;
    else if (underrun_clr) m_under = 0;
    if (m_hb) begin
      m_sample = m_full ? m_buf : '0;
      m_full = 0;
      m_n = 0;
      m_r = pn;
    end
    if (x) begin
      m_full = 1;
      m_buf = s_tdata;
    end
    m_pend = pn;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #2;
    check(name, pack_dut(), pack_model());
  endtask

  task automatic idle_inputs();
    enable = 0; rate_load = 0; rate_in = '0; s_tvalid = 0; s_tdata = '0; underrun_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    #1;
    check("reset_async", pack_dut(), pack_model());
    @(posedge clk); @(posedge clk);
    #2;
    reset = 0;
    check("reset_state", pack_dut(), {1'b0, 1'b0, 1'b0, 16'h0, 1'b1, RW'(DEF_RATE), 1'b0});
  endtask

  // Reset, load R=4 while idle, then raise enable for the following edges.
  task automatic start_r4(input string name);
    do_reset();
    rate_load = 1; rate_in = RW'(4);
    step(name);
    rate_load = 0;
    enable = 1;
  endtask

  initial begin
    int k_cic, k_hb, k_cic2, cnt;

    for (int k = 0; k < 37; k++) begin
      vecs[k].en  = (k != 0);
      vecs[k].ld  = (k == 0);
      vecs[k].rin = RW'(4);
      vecs[k].tv  = (k == 2) || (k == 20);
      vecs[k].td  = (k == 2) ? 16'h1234 : 16'h8001;
      vecs[k].clr = 0;
      vecs[k].e_cic  = (k != 0) && (k % 4 == 0);
      vecs[k].e_comp = (k != 0) && (k % 8 == 0);
      vecs[k].e_hb   = (k != 0) && (k % 16 == 0);
      vecs[k].e_sample = (k >= 32) ? 16'h8001 : (k >= 16) ? 16'h1234 : 16'h0000;
      vecs[k].e_tready = !((k >= 2 && k < 16) || (k >= 20 && k < 32));
      vecs[k].e_rate   = RW'(4);
      vecs[k].e_under  = 0;
    end

    do_reset();

    for (int k = 0; k < 37; k++) begin
      enable = vecs[k].en; rate_load = vecs[k].ld; rate_in = vecs[k].rin;
      s_tvalid = vecs[k].tv; s_tdata = vecs[k].td; underrun_clr = vecs[k].clr;
      step($sformatf("model_tbl%0d", k));
      check($sformatf("table%0d", k), pack_dut(),
            {vecs[k].e_cic, vecs[k].e_comp, vecs[k].e_hb, vecs[k].e_sample,
             vecs[k].e_tready, vecs[k].e_rate, vecs[k].e_under});
    end

    // Underrun set, standalone clear, and clear losing to a coincident set.
    start_r4("ur_load");
    for (int k = 1; k <= 32; k++) begin
      underrun_clr = (k == 17) || (k == 32);
      step($sformatf("ur%0d", k));
      if (k == 15) check("ur_before_hb", {31'd0, underrun}, 32'd0);
      if (k == 16) check("ur_set", {underrun, sample_out, hb_ce}, {1'b1, 16'h0, 1'b1});
      if (k == 17) check("ur_clr", {31'd0, underrun}, 32'd0);
      if (k == 32) check("ur_clr_vs_set", {30'd0, hb_ce, underrun}, 32'd3);
    end
    underrun_clr = 0;

    // Rate change mid-frame waits for the frame boundary.
    start_r4("rc_load");
    k_cic = 0; k_hb = 0; k_cic2 = 0;
    for (int k = 1; k <= 50; k++) begin
      rate_load = (k == 5); rate_in = RW'(6);
      step($sformatf("rc%0d", k));
      if (k == 15) check("rc_hold", 32'(rate_active), 32'd4);
      if (k == 16) check("rc_switch", 32'(rate_active), 32'd6);
      if (k > 16 && cic_ce && k_cic != 0 && k_cic2 == 0) k_cic2 = k;
      if (k > 16 && cic_ce && k_cic == 0) k_cic = k;
      if (k > 16 && hb_ce && k_hb == 0) k_hb = k;
    end
    check("rc_cic_first", k_cic, 22);
    check("rc_cic_second", k_cic2, 28);
    check("rc_hb_next", k_hb, 40);
    enable = 0; rate_load = 1; rate_in = RW'(1);
    step("rc_clamp_step");
    check("rc_clamp", 32'(rate_active), 32'd2);
    rate_load = 0;

    // Offered sample on the consuming cycle waits one cycle for s_tready.
    start_r4("sim_load");
    for (int k = 1; k <= 32; k++) begin
      s_tvalid = (k == 1) || (k == 16) || (k == 17);
      s_tdata  = (k == 1) ? 16'h0AAA : 16'h0BBB;
      step($sformatf("sim%0d", k));
      if (k == 15) check("sim_full", {31'd0, s_tready}, 32'd0);
      if (k == 16) check("sim_consume", {sample_out, s_tready}, {16'h0AAA, 1'b1});
      if (k == 17) check("sim_accept", {31'd0, s_tready}, 32'd0);
      if (k == 32) check("sim_second", {16'd0, sample_out}, {16'd0, 16'h0BBB});
    end
    s_tvalid = 0;

    // Asynchronous reset mid-frame with the buffer holding a sample.
    start_r4("ar_load");
    for (int k = 1; k <= 10; k++) begin
      s_tvalid = (k == 1); s_tdata = 16'h0555;
      step($sformatf("ar%0d", k));
    end
    s_tvalid = 0;
    check("ar_pre_full", {31'd0, s_tready}, 32'd0);
    #1 reset = 1;
    #1 check("ar_async", pack_dut(), {1'b0, 1'b0, 1'b0, 16'h0, 1'b1, RW'(DEF_RATE), 1'b0});
    model_reset();
    step("ar_hold");
    reset = 0;
    cnt = 0;
    for (int k = 1; k <= 2000; k++) begin
      step("ar_run");
      if (cic_ce) begin
        cnt = k;
        break;
      end
    end
    check("ar_first_cic", cnt, DEF_RATE);

    // Randomized traffic checked against the model every edge.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      enable       = ($urandom_range(0, 40) != 0);
      rate_load    = ($urandom_range(0, 25) == 0);
      rate_in      = RW'($urandom_range(0, 9));
      s_tvalid     = ($urandom_range(0, 5) == 0);
      s_tdata      = DW'($urandom);
      underrun_clr = ($urandom_range(0, 7) == 0);
      step($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
